multi_bbox_tracker: RTL and testbench

Parametrised per-channel bounding-box and pixel-count tracker for the video pipeline.
- Sits beside the pixel stream registers and takes one detect bit per colour channel for each valid beat.
- Accumulates per-frame min/max coordinates and pixel counts for NUM_CH independent channels, then latches overlay boxes at each end of frame.
- Every MSG_INTERVAL frames it emits a framed message on a ready/valid word stream toward the CPU message FIFO.
- Unlike the previous generation, channels are not mutually exclusive, the ROI is parametrised, and each channel reports a pixel count and a validity flag.

---
 rtl/multi_bbox_tracker_if.sv | 25 ++
 rtl/multi_bbox_tracker.sv | 259 +++++++++++++++++++++++++
 tb/tb_multi_bbox_tracker.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_bbox_tracker_if.sv
// Pixel-side detect stream plus the CPU-bound message word stream.
// master = the side that drives pixels and accepts message words,
// slave  = the tracker itself.
interface multi_bbox_tracker_if #(
  parameter int NUM_CH = 4
);
  logic              pix_valid;
  logic              pix_sop;
  logic              pix_eop;
  logic              pix_is_video;
  logic [NUM_CH-1:0] det;
  logic [31:0]       msg_data;
  logic              msg_valid;
  logic              msg_ready;

  modport master (
    output pix_valid, pix_sop, pix_eop, pix_is_video, det, msg_ready,
    input  msg_data, msg_valid
  );

  modport slave (
    input  pix_valid, pix_sop, pix_eop, pix_is_video, det, msg_ready,
    output msg_data, msg_valid
  );
endinterface

// File: rtl/multi_bbox_tracker.sv
// Per-channel bounding box / pixel count tracker.
// Accumulates min/max coordinates and counts per detect channel over the ROI,
// latches overlay boxes at each video end of frame and periodically sends a
// snapshot of all channels as a framed word message.
//
// state  | meaning
// IDLE   | no message in flight, snapshot may be taken
// HDR    | presenting the header word
// CH_A   | presenting {vld, ch, x_min, y_min} for channel ch_q
// CH_B   | presenting {ch, x_max, y_max} for channel ch_q
// CH_C   | presenting the pixel count for channel ch_q
module multi_bbox_tracker #(
  parameter int          NUM_CH       = 4,
  parameter int          IMAGE_W      = 640,
  parameter int          IMAGE_H      = 480,
  parameter int          ROI_Y_MIN    = 0,
  parameter int          ROI_Y_MAX    = 239,
  parameter int          MSG_INTERVAL = 6,
  parameter int          MIN_PIX      = 16,
  parameter logic [7:0]  MSG_ID       = 8'hB0
) (
  input  logic                    clk,
  input  logic                    reset,
  multi_bbox_tracker_if.slave     strm,
  output logic [NUM_CH*11-1:0]    bb_left,
  output logic [NUM_CH*11-1:0]    bb_right,
  output logic [NUM_CH*11-1:0]    bb_top,
  output logic [NUM_CH*11-1:0]    bb_bottom,
  output logic [15:0]             frame_seq
);

  localparam logic [10:0] X_LAST     = 11'(IMAGE_W - 1);
  localparam logic [10:0] Y_LAST     = 11'(IMAGE_H - 1);
  localparam logic [15:0] INT_RELOAD = 16'(MSG_INTERVAL - 1);

  typedef enum logic [2:0] {IDLE, HDR, CH_A, CH_B, CH_C} state_t;

  logic [10:0] x_q, y_q;
  logic        in_video_q;

  logic [10:0] min_x_q [NUM_CH];
  logic [10:0] min_y_q [NUM_CH];
  logic [10:0] max_x_q [NUM_CH];
  logic [10:0] max_y_q [NUM_CH];
  logic [15:0] cnt_q   [NUM_CH];
  logic [10:0] min_x_d [NUM_CH];
  logic [10:0] min_y_d [NUM_CH];
  logic [10:0] max_x_d [NUM_CH];
  logic [10:0] max_y_d [NUM_CH];
  logic [15:0] cnt_d   [NUM_CH];

  logic [10:0] bb_l_q [NUM_CH];
  logic [10:0] bb_r_q [NUM_CH];
  logic [10:0] bb_t_q [NUM_CH];
  logic [10:0] bb_b_q [NUM_CH];

  logic [10:0] snap_min_x_q [NUM_CH];
  logic [10:0] snap_min_y_q [NUM_CH];
  logic [10:0] snap_max_x_q [NUM_CH];
  logic [10:0] snap_max_y_q [NUM_CH];
  logic [15:0] snap_cnt_q   [NUM_CH];

  logic [15:0] frame_seq_q, frame_seq_d;
  logic [15:0] int_q;
  state_t      state_q;
  logic [3:0]  ch_q, ch_d;
  logic [31:0] msg_data_q;
  logic        msg_valid_q;

  logic        sop_beat, pix_beat, frame_end, in_roi, snap_start, fire;
  logic [31:0] word_a, word_b, word_c, word_hdr;

  assign sop_beat    = strm.pix_valid & strm.pix_sop;
  assign pix_beat    = strm.pix_valid & ~strm.pix_sop & in_video_q;
  assign frame_end   = pix_beat & strm.pix_eop;
  assign in_roi      = (int'(y_q) >= ROI_Y_MIN) && (int'(y_q) <= ROI_Y_MAX);
  assign frame_seq_d = frame_seq_q + 16'd1;
  assign snap_start  = frame_end && (int_q == 16'd0) && (state_q == IDLE);
  assign fire        = msg_valid_q & strm.msg_ready;
  assign word_hdr    = {MSG_ID, 4'b0, 4'(NUM_CH), frame_seq_d};

  // Pixel coordinate tracking; a sop always restarts at (0,0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q        <= '0;
      y_q        <= '0;
      in_video_q <= 1'b0;
    end else if (sop_beat) begin
      x_q        <= '0;
      y_q        <= '0;
      in_video_q <= strm.pix_is_video;
    end else if (pix_beat) begin
      if (x_q == X_LAST) begin
        x_q <= '0;
        if (y_q != Y_LAST) y_q <= y_q + 11'd1;
      end else begin
        x_q <= x_q + 11'd1;
      end
    end
  end

  // Next-state accumulators, so the eop pixel is part of what gets latched.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      min_x_d[c] = min_x_q[c];
      min_y_d[c] = min_y_q[c];
      max_x_d[c] = max_x_q[c];
      max_y_d[c] = max_y_q[c];
      cnt_d[c]   = cnt_q[c];
      if (sop_beat) begin
        min_x_d[c] = X_LAST;
        min_y_d[c] = Y_LAST;
        max_x_d[c] = '0;
        max_y_d[c] = '0;
        cnt_d[c]   = '0;
      end else if (pix_beat && in_roi && strm.det[c]) begin
        if (x_q < min_x_q[c]) min_x_d[c] = x_q;
        if (y_q < min_y_q[c]) min_y_d[c] = y_q;
        if (x_q > max_x_q[c]) max_x_d[c] = x_q;
        if (y_q > max_y_q[c]) max_y_d[c] = y_q;
        if (cnt_q[c] != 16'hFFFF) cnt_d[c] = cnt_q[c] + 16'd1;
      end
    end
  end

  // Accumulator registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        min_x_q[c] <= X_LAST;
        min_y_q[c] <= Y_LAST;
        max_x_q[c] <= '0;
        max_y_q[c] <= '0;
        cnt_q[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        min_x_q[c] <= min_x_d[c];
        min_y_q[c] <= min_y_d[c];
        max_x_q[c] <= max_x_d[c];
        max_y_q[c] <= max_y_d[c];
        cnt_q[c]   <= cnt_d[c];
      end
    end
  end

  // End-of-frame bookkeeping: overlay latch, frame counter, interval and snapshot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_seq_q <= '0;
      int_q       <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        bb_l_q[c]       <= '0;
        bb_r_q[c]       <= '0;
        bb_t_q[c]       <= '0;
        bb_b_q[c]       <= '0;
        snap_min_x_q[c] <= '0;
        snap_min_y_q[c] <= '0;
        snap_max_x_q[c] <= '0;
        snap_max_y_q[c] <= '0;
        snap_cnt_q[c]   <= '0;
      end
    end else if (frame_end) begin
      frame_seq_q <= frame_seq_d;
      for (int c = 0; c < NUM_CH; c++) begin
        bb_l_q[c] <= min_x_d[c];
        bb_r_q[c] <= max_x_d[c];
        bb_t_q[c] <= min_y_d[c];
        bb_b_q[c] <= max_y_d[c];
      end
      if (snap_start) begin
        int_q <= INT_RELOAD;
        for (int c = 0; c < NUM_CH; c++) begin
          snap_min_x_q[c] <= min_x_d[c];
          snap_min_y_q[c] <= min_y_d[c];
          snap_max_x_q[c] <= max_x_d[c];
          snap_max_y_q[c] <= max_y_d[c];
          snap_cnt_q[c]   <= cnt_d[c];
        end
      end else if (int_q != 16'd0) begin
        int_q <= int_q - 16'd1;
      end
    end
  end

  // Selects the channel words for the channel the FSM moves to next.
  always_comb begin
    ch_d   = (state_q == CH_C) ? ch_q + 4'd1 : ((state_q == HDR) ? 4'd0 : ch_q);
    word_a = '0;
    word_b = '0;
    word_c = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_d == 4'(c)) begin
        word_a = {(int'(snap_cnt_q[c]) >= MIN_PIX), 4'(c), 5'b0,
                  snap_min_x_q[c], snap_min_y_q[c]};
        word_b = {4'(c), 6'b0, snap_max_x_q[c], snap_max_y_q[c]};
        word_c = {16'b0, snap_cnt_q[c]};
      end
    end
  end

  // Message FSM with registered word/valid; holds while the sink stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      msg_data_q  <= '0;
      msg_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (snap_start) begin
          state_q     <= HDR;
          msg_data_q  <= word_hdr;
          msg_valid_q <= 1'b1;
        end
        HDR: if (fire) begin
          state_q    <= CH_A;
          ch_q       <= ch_d;
          msg_data_q <= word_a;
        end
        CH_A: if (fire) begin
          state_q    <= CH_B;
          msg_data_q <= word_b;
        end
        CH_B: if (fire) begin
          state_q    <= CH_C;
          msg_data_q <= word_c;
        end
        CH_C: if (fire) begin
          if (ch_q == 4'(NUM_CH - 1)) begin
            state_q     <= IDLE;
            msg_data_q  <= '0;
            msg_valid_q <= 1'b0;
          end else begin
            state_q    <= CH_A;
            ch_q       <= ch_d;
            msg_data_q <= word_a;
          end
        end
        default: begin
          state_q     <= IDLE;
          msg_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign strm.msg_data  = msg_data_q;
  assign strm.msg_valid = msg_valid_q;
  assign frame_seq      = frame_seq_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign bb_left[11*g +: 11]   = bb_l_q[g];
    assign bb_right[11*g +: 11]  = bb_r_q[g];
    assign bb_top[11*g +: 11]    = bb_t_q[g];
    assign bb_bottom[11*g +: 11] = bb_b_q[g];
  end

endmodule

// File: tb/tb_multi_bbox_tracker.sv
// Scoreboard bench for multi_bbox_tracker: a behavioural model follows the
// driven pixel stream, queues the expected message words and the monitor
// compares them as the tracker hands them over.
module tb_multi_bbox_tracker;
  localparam int NUM_CH = 2;
  localparam int W      = 8;
  localparam int H      = 4;
  localparam int RMIN   = 1;
  localparam int RMAX   = 2;
  localparam int MI     = 3;
  localparam int MINP   = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multi_bbox_tracker_if #(.NUM_CH(NUM_CH)) bus ();
  logic [NUM_CH*11-1:0] bb_left, bb_right, bb_top, bb_bottom;
  logic [15:0]          frame_seq;

  multi_bbox_tracker #(
    .NUM_CH(NUM_CH), .IMAGE_W(W), .IMAGE_H(H), .ROI_Y_MIN(RMIN), .ROI_Y_MAX(RMAX),
    .MSG_INTERVAL(MI), .MIN_PIX(MINP), .MSG_ID(8'hB0)
  ) dut (
    .clk(clk), .reset(reset), .strm(bus),
    .bb_left(bb_left), .bb_right(bb_right), .bb_top(bb_top), .bb_bottom(bb_bottom),
    .frame_seq(frame_seq)
  );

  int n_chk = 0;
  int n_err = 0;
  int hs_cnt = 0;
  logic [31:0] exp_q[$];
  logic [NUM_CH-1:0] dmap [W*H];

  int m_minx[NUM_CH], m_miny[NUM_CH], m_maxx[NUM_CH], m_maxy[NUM_CH], m_cnt[NUM_CH];
  int m_bbl[NUM_CH], m_bbr[NUM_CH], m_bbt[NUM_CH], m_bbb[NUM_CH];
  int m_seq, m_int, m_x, m_y;
  bit m_invid;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic acc_clear();
    for (int c = 0; c < NUM_CH; c++) begin
      m_minx[c] = W - 1; m_miny[c] = H - 1; m_maxx[c] = 0; m_maxy[c] = 0; m_cnt[c] = 0;
    end
  endtask

  task automatic model_reset();
    acc_clear();
    for (int c = 0; c < NUM_CH; c++) begin
      m_bbl[c] = 0; m_bbr[c] = 0; m_bbt[c] = 0; m_bbb[c] = 0;
    end
    m_seq = 0; m_int = 0; m_x = 0; m_y = 0; m_invid = 1'b0;
  endtask

  task automatic push_msg();
    logic [31:0] w;
    exp_q.push_back({8'hB0, 4'h0, 4'(NUM_CH), 16'(m_seq)});
    for (int c = 0; c < NUM_CH; c++) begin
      w = {(m_cnt[c] >= MINP) ? 1'b1 : 1'b0, 4'(c), 5'b0, 11'(m_minx[c]), 11'(m_miny[c])};
      exp_q.push_back(w);
      exp_q.push_back({4'(c), 6'b0, 11'(m_maxx[c]), 11'(m_maxy[c])});
      exp_q.push_back({16'b0, 16'(m_cnt[c])});
    end
  endtask

  task automatic frame_done();
    for (int c = 0; c < NUM_CH; c++) begin
      m_bbl[c] = m_minx[c]; m_bbr[c] = m_maxx[c]; m_bbt[c] = m_miny[c]; m_bbb[c] = m_maxy[c];
    end
    m_seq = (m_seq + 1) & 16'hFFFF;
    if (m_int == 0) begin
      if (exp_q.size() == 0) begin
        push_msg();
        m_int = MI - 1;
      end
    end else begin
      m_int--;
    end
  endtask

  // Called right after the clock edge that consumed the current beat.
  task automatic model_beat();
    if (bus.pix_valid) begin
      if (bus.pix_sop) begin
        m_x = 0; m_y = 0; m_invid = bus.pix_is_video;
        acc_clear();
      end else if (m_invid) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (bus.det[c] && m_y >= RMIN && m_y <= RMAX) begin
            if (m_x < m_minx[c]) m_minx[c] = m_x;
            if (m_y < m_miny[c]) m_miny[c] = m_y;
            if (m_x > m_maxx[c]) m_maxx[c] = m_x;
            if (m_y > m_maxy[c]) m_maxy[c] = m_y;
            if (m_cnt[c] < 65535) m_cnt[c]++;
          end
        end
        if (bus.pix_eop) frame_done();
        if (m_x == W - 1) begin
          m_x = 0;
          if (m_y != H - 1) m_y++;
        end else begin
          m_x++;
        end
      end
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_beat(input bit sop, input bit eop, input bit video,
                            input logic [NUM_CH-1:0] d);
    bus.pix_valid = 1'b1; bus.pix_sop = sop; bus.pix_eop = eop;
    bus.pix_is_video = video; bus.det = d;
    @(posedge clk);
    model_beat();
    #1;
  endtask

  task automatic check_outputs();
    for (int c = 0; c < NUM_CH; c++) begin
      chk($sformatf("bb_left%0d", c),   32'(bb_left[11*c +: 11]),   32'(m_bbl[c]));
      chk($sformatf("bb_right%0d", c),  32'(bb_right[11*c +: 11]),  32'(m_bbr[c]));
      chk($sformatf("bb_top%0d", c),    32'(bb_top[11*c +: 11]),    32'(m_bbt[c]));
      chk($sformatf("bb_bottom%0d", c), 32'(bb_bottom[11*c +: 11]), 32'(m_bbb[c]));
    end
    chk("frame_seq", 32'(frame_seq), 32'(m_seq & 16'hFFFF));
  endtask

  task automatic drive_frame(input bit video, input int nbeats, input bit with_eop);
    drive_beat(1'b1, 1'b0, video, '1);
    for (int i = 0; i < nbeats; i++)
      drive_beat(1'b0, with_eop && (i == nbeats - 1), 1'b0, (i < W*H) ? dmap[i] : '0);
    bus.pix_valid = 1'b0; bus.pix_sop = 1'b0; bus.pix_eop = 1'b0; bus.det = '0;
    check_outputs();
    wait_cycles(2);
  endtask

  task automatic clear_map();
    for (int i = 0; i < W*H; i++) dmap[i] = '0;
  endtask

  task automatic rand_map();
    for (int i = 0; i < W*H; i++)
      dmap[i] = ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom) : '0;
  endtask

  task automatic set_det(input int x, input int y, input logic [NUM_CH-1:0] m);
    dmap[y*W + x] = m;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      wait_cycles(1);
      k++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    wait_cycles(1);
  endtask

  // Monitor: valid must match pending words, data must match the queue head
  // on every valid cycle (covers stability while stalled).
  always @(negedge clk) begin
    if (!reset) begin
      chk("msg_valid", 32'(bus.msg_valid), 32'(exp_q.size() != 0));
      if (bus.msg_valid && exp_q.size() != 0) begin
        chk("msg_data", bus.msg_data, exp_q[0]);
        if (bus.msg_ready) begin
          void'(exp_q.pop_front());
          hs_cnt++;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pix_valid = 1'b0; bus.pix_sop = 1'b0; bus.pix_eop = 1'b0;
    bus.pix_is_video = 1'b0; bus.det = '0; bus.msg_ready = 1'b1;
    model_reset();
    clear_map();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_outputs();
    chk("rst_msg_valid", 32'(bus.msg_valid), 32'd0);

    // Frame 1: ch0 box inside ROI, detects on y=0 and y=3 lie outside ROI.
    clear_map();
    set_det(2, 1, 2'b01); set_det(5, 2, 2'b01); set_det(6, 0, 2'b01); set_det(1, 3, 2'b01);
    hs_cnt = 0;
    drive_frame(1'b1, W*H, 1'b1);
    bus.msg_ready = 1'b0;
    wait_cycles(10);
    bus.msg_ready = 1'b1;
    drain();
    chk("hs_count", 32'(hs_cnt), 32'(1 + 3*NUM_CH));

    // Frame 2: simultaneous detect, ch1 detect on the eop pixel (7,2).
    clear_map();
    set_det(3, 1, 2'b11); set_det(7, 2, 2'b10);
    drive_frame(1'b1, 24, 1'b1);

    rand_map(); drive_frame(1'b1, W*H, 1'b1);

    // Frames 4..8 with the sink stalled: 4 sends, 7 and 8 find it busy.
    bus.msg_ready = 1'b0;
    for (int f = 0; f < 5; f++) begin
      rand_map();
      drive_frame(1'b1, W*H, 1'b1);
    end
    bus.msg_ready = 1'b1;
    drain();
    rand_map(); drive_frame(1'b1, W*H, 1'b1);
    drain();

    // Non-video packet must leave everything untouched.
    for (int i = 0; i < W*H; i++) dmap[i] = '1;
    drive_frame(1'b0, W*H, 1'b1);

    // Truncated frame (no eop), then a full frame that must start clean.
    clear_map(); set_det(0, 1, 2'b11);
    drive_frame(1'b1, 12, 1'b0);
    clear_map(); set_det(4, 2, 2'b01);
    drive_frame(1'b1, W*H, 1'b1);
    rand_map(); drive_frame(1'b1, W*H, 1'b1);

    // Reset in the middle of a stalled message.
    bus.msg_ready = 1'b0;
    rand_map(); drive_frame(1'b1, W*H, 1'b1);
    reset = 1'b1;
    #1;
    chk("rst_mid_valid", 32'(bus.msg_valid), 32'd0);
    exp_q.delete();
    model_reset();
    wait_cycles(2);
    reset = 1'b0;
    check_outputs();
    bus.msg_ready = 1'b1;
    rand_map(); drive_frame(1'b1, W*H, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
